// File: rtl/regfile_sb.sv
// regfile_sb: register file for the RISC-16 datapath.
//   One writeback port and two registered read ports. A per-register busy
//   bit (scoreboard) marks registers with an issued but not yet written-back
//   result. A read whose sources are pending is stalled.
//   Build option: define RF_BYPASS_EN to forward same-cycle writeback data
//   into an accepted read. The same option lets that writeback clear a
//   pending source in the same cycle. Without it, reads are read-before-write
//   and a stall lasts one cycle longer.
//
// Read handshake: rd_en is the request and !stall is the ready. A read is
// accepted on a rising edge where rd_en=1 and stall=0. After an accepting
// edge, rd_valid=1 and reg_out1/2 carry that read's data for one cycle.
// After any other edge rd_valid=0 and reg_out1/2 keep their last values.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE_rf,
    input  logic [1:0]        MUX_tgt,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    input  logic [ADDR_W-1:0] rC,
    input  logic              MUX_rf,
    input  logic              sb_set,
    output logic              stall,
    output logic [DATA_W-1:0] reg_out1,
    output logic [DATA_W-1:0] reg_out2,
    output logic              rd_valid
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   rf [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [DATA_W-1:0]   pc_plus1;
    logic [DATA_W-1:0]   wr_data;
    logic                wb_is_r0;
    logic                wr_en_eff;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [ADDR_W-1:0]   src1;
    logic [ADDR_W-1:0]   src2;
    logic                pend1;
    logic                pend2;
    logic                rd_accept;
    logic [DATA_W-1:0]   rd_data1;
    logic [DATA_W-1:0]   rd_data2;

    // Writeback data select. pc+1 wraps at DATA_W bits.
    always_comb begin
        pc_plus1 = pc + DATA_W'(1);
        case (MUX_tgt)
            2'b00:   wr_data = mem_out;
            2'b01:   wr_data = alu_out;
            2'b10:   wr_data = pc_plus1;
            default: wr_data = '0;
        endcase
        wb_is_r0  = (ZERO_REG != 0) && (wb_addr == '0);
        wr_en_eff = WE_rf && !wb_is_r0;
    end

    // Scoreboard set/clear vectors. R0 is never marked busy when it is hardwired.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (sb_set) begin
            set_vec = NUM_REGS'(1) << rA;
        end
        if (ZERO_REG != 0) begin
            set_vec[0] = 1'b0;
        end
        if (WE_rf) begin
            clr_vec = NUM_REGS'(1) << wb_addr;
        end
    end

    // Source selection, pending detection, stall and read data.
    always_comb begin
        src1 = rB;
        src2 = MUX_rf ? rA : rC;
`ifdef RF_BYPASS_EN
        // A writeback to the source in this cycle satisfies it. The new
        // value is forwarded straight into the read.
        pend1    = busy[src1] && !(WE_rf && (wb_addr == src1));
        pend2    = busy[src2] && !(WE_rf && (wb_addr == src2));
        rd_data1 = (wr_en_eff && (wb_addr == src1)) ? wr_data : rf[src1];
        rd_data2 = (wr_en_eff && (wb_addr == src2)) ? wr_data : rf[src2];
`else
        // Read-before-write. A busy source stays pending until the edge
        // after its writeback.
        pend1    = busy[src1];
        pend2    = busy[src2];
        rd_data1 = rf[src1];
        rd_data2 = rf[src2];
`endif
        if ((ZERO_REG != 0) && (src1 == '0)) begin
            rd_data1 = '0;
        end
        if ((ZERO_REG != 0) && (src2 == '0)) begin
            rd_data2 = '0;
        end
        stall     = rd_en && (pend1 || pend2);
        rd_accept = rd_en && !stall;
    end

    // Register array: writeback port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en_eff) begin
            rf[wb_addr] <= wr_data;
        end
    end

    // Scoreboard busy bits. When both happen on one register, set wins over the writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

    // Registered read ports and valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_out1 <= '0;
            reg_out2 <= '0;
            rd_valid <= 1'b0;
        end else if (rd_accept) begin
            reg_out1 <= rd_data1;
            reg_out2 <= rd_data2;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb. Covers reset, writeback data
// select, R0 protection, pc+1 wrap, the scoreboard stall and its release,
// the port-2 address mux, set-vs-clear priority and async reset mid-operation.
// Expectations follow RF_BYPASS_EN the same way the design does.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        WE_rf;
    logic [1:0]  MUX_tgt;
    logic [2:0]  wb_addr;
    logic [15:0] mem_out;
    logic [15:0] alu_out;
    logic [15:0] pc;
    logic        rd_en;
    logic [2:0]  rA;
    logic [2:0]  rB;
    logic [2:0]  rC;
    logic        MUX_rf;
    logic        sb_set;
    logic        stall;
    logic [15:0] reg_out1;
    logic [15:0] reg_out2;
    logic        rd_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .WE_rf(WE_rf), .MUX_tgt(MUX_tgt), .wb_addr(wb_addr),
        .mem_out(mem_out), .alu_out(alu_out), .pc(pc), .rd_en(rd_en),
        .rA(rA), .rB(rB), .rC(rC), .MUX_rf(MUX_rf), .sb_set(sb_set),
        .stall(stall), .reg_out1(reg_out1), .reg_out2(reg_out2), .rd_valid(rd_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [1:0] tgt,
                      input logic [15:0] m, input logic [15:0] a, input logic [15:0] p);
        WE_rf   = 1'b1;
        wb_addr = addr;
        MUX_tgt = tgt;
        mem_out = m;
        alu_out = a;
        pc      = p;
        tick();
        WE_rf   = 1'b0;
    endtask

    // an accepted read: expect no stall, then rd_valid and both ports one cycle later
    task automatic do_read(input logic [2:0] b, input logic [2:0] a, input logic [2:0] c,
                           input logic mux, input logic [15:0] e1, input logic [15:0] e2,
                           input string tag);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        rB     = b;
        rA     = a;
        rC     = c;
        MUX_rf = mux;
        rd_en  = 1'b1;
        #1;
        check({tag, "_stall"}, 16'(stall), 16'h0);
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 16'(rd_valid), 16'h1);
        check({tag, "_out1"}, reg_out1, exp_q.pop_front());
        check({tag, "_out2"}, reg_out2, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        WE_rf = 1'b0; MUX_tgt = 2'b00; wb_addr = '0;
        mem_out = '0; alu_out = '0; pc = '0;
        rd_en = 1'b0; rA = '0; rB = '0; rC = '0; MUX_rf = 1'b0; sb_set = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        check("rst_out1", reg_out1, 16'h0);
        check("rst_out2", reg_out2, 16'h0);
        check("rst_valid", 16'(rd_valid), 16'h0);
        tick();

        // write then read; R0 on port 2 reads zero
        wr(3'd3, 2'b01, 16'hDEAD, 16'h1234, 16'h0000);
        do_read(3'd3, 3'd0, 3'd0, 1'b0, 16'h1234, 16'h0000, "wr_rd");
        tick();
        check("idle_valid", 16'(rd_valid), 16'h0);
        check("idle_hold", reg_out1, 16'h1234);

        // R0 ignores writes
        wr(3'd0, 2'b00, 16'hBEEF, 16'h1111, 16'h2222);
        do_read(3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, "r0_prot");

        // pc+1 wrap, zero select, normal pc+1
        wr(3'd5, 2'b01, 16'h0000, 16'h5555, 16'h0000);
        wr(3'd5, 2'b10, 16'hAAAA, 16'hBBBB, 16'hFFFF);
        do_read(3'd5, 3'd0, 3'd3, 1'b0, 16'h0000, 16'h1234, "pc_wrap");
        wr(3'd6, 2'b01, 16'h0000, 16'h6666, 16'h0000);
        wr(3'd6, 2'b11, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        wr(3'd7, 2'b10, 16'h0000, 16'h0000, 16'h0010);
        do_read(3'd6, 3'd0, 3'd7, 1'b0, 16'h0000, 16'h0011, "tgt_zero_pc");

        // scoreboard stall on port 1 and release by writeback
        sb_set = 1'b1; rA = 3'd2;
        tick();
        sb_set = 1'b0; rA = 3'd0;
        rd_en = 1'b1; rB = 3'd2; rC = 3'd0; MUX_rf = 1'b0;
        #1;
        check("sb_stall", 16'(stall), 16'h1);
        tick();
        check("sb_stall_valid", 16'(rd_valid), 16'h0);
        WE_rf = 1'b1; wb_addr = 3'd2; MUX_tgt = 2'b01; alu_out = 16'h00AA;
        #1;
`ifdef RF_BYPASS_EN
        check("sb_wb_stall", 16'(stall), 16'h0);
        tick();
        WE_rf = 1'b0; rd_en = 1'b0;
`else
        check("sb_wb_stall", 16'(stall), 16'h1);
        tick();
        WE_rf = 1'b0;
        check("sb_wb_valid", 16'(rd_valid), 16'h0);
        #1;
        check("sb_after_stall", 16'(stall), 16'h0);
        tick();
        rd_en = 1'b0;
`endif
        check("sb_rel_valid", 16'(rd_valid), 16'h1);
        check("sb_rel_out1", reg_out1, 16'h00AA);

        // stall from port 2 only; the port-2 mux decides which register is the source
        sb_set = 1'b1; rA = 3'd7;
        tick();
        sb_set = 1'b0;
        rd_en = 1'b1; rB = 3'd1; rC = 3'd7; MUX_rf = 1'b0;
        #1;
        check("src2_stall", 16'(stall), 16'h1);
        MUX_rf = 1'b1; rA = 3'd1;
        #1;
        check("src2_mux_nostall", 16'(stall), 16'h0);
        rd_en = 1'b0; MUX_rf = 1'b0;
        wr(3'd7, 2'b01, 16'h0000, 16'h7777, 16'h0000);

        // busy[0] is never set
        sb_set = 1'b1; rA = 3'd0;
        tick();
        sb_set = 1'b0;
        do_read(3'd0, 3'd0, 3'd7, 1'b0, 16'h0000, 16'h7777, "r0_busy");

        // port-2 mux
        wr(3'd4, 2'b01, 16'h0000, 16'h4444, 16'h0000);
        wr(3'd6, 2'b01, 16'h0000, 16'h6666, 16'h0000);
        do_read(3'd1, 3'd4, 3'd6, 1'b1, 16'h0000, 16'h4444, "mux_rA");
        do_read(3'd1, 3'd4, 3'd6, 1'b0, 16'h0000, 16'h6666, "mux_rC");

        // set wins over clear on the same register
        sb_set = 1'b1; rA = 3'd4;
        WE_rf = 1'b1; wb_addr = 3'd4; MUX_tgt = 2'b01; alu_out = 16'h4445;
        tick();
        sb_set = 1'b0; WE_rf = 1'b0;
        rd_en = 1'b1; rB = 3'd4; rC = 3'd0; MUX_rf = 1'b0;
        #1;
        check("setclr_stall", 16'(stall), 16'h1);
        tick();
        rd_en = 1'b0;
        check("setclr_valid", 16'(rd_valid), 16'h0);
        check("setclr_hold", reg_out1, 16'h0000);
        wr(3'd4, 2'b01, 16'h0000, 16'h4446, 16'h0000);
        do_read(3'd4, 3'd0, 3'd0, 1'b0, 16'h4446, 16'h0000, "setclr_rel");

        // same-cycle write and read of one register
        rd_en = 1'b1; rB = 3'd3; rC = 3'd6; MUX_rf = 1'b0;
        WE_rf = 1'b1; wb_addr = 3'd3; MUX_tgt = 2'b01; alu_out = 16'h9999;
        #1;
        check("byp_stall", 16'(stall), 16'h0);
        tick();
        rd_en = 1'b0; WE_rf = 1'b0;
        check("byp_valid", 16'(rd_valid), 16'h1);
`ifdef RF_BYPASS_EN
        check("byp_out1", reg_out1, 16'h9999);
`else
        check("byp_out1", reg_out1, 16'h1234);
`endif
        check("byp_out2", reg_out2, 16'h6666);
        do_read(3'd3, 3'd0, 3'd6, 1'b0, 16'h9999, 16'h6666, "byp_after");

        // async reset mid-operation with a pending write and a busy register
        sb_set = 1'b1; rA = 3'd5;
        tick();
        sb_set = 1'b0;
        do_read(3'd3, 3'd0, 3'd4, 1'b0, 16'h9999, 16'h4446, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("arst_out1", reg_out1, 16'h0);
        check("arst_out2", reg_out2, 16'h0);
        check("arst_valid", 16'(rd_valid), 16'h0);
        WE_rf = 1'b1; wb_addr = 3'd1; MUX_tgt = 2'b01; alu_out = 16'hAAAA;
        tick();
        WE_rf = 1'b0;
        #2 rst = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) begin
            do_read(3'(i), 3'd0, 3'(i), 1'b0, 16'h0000, 16'h0000, $sformatf("post_rst_r%0d", i));
        end

        check("exp_q_empty", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
